cnt_run_ctrl: RTL and testbench
===============================

// Module: cnt_run_ctrl
// PURPOSE
//  Run-window controller for a bank of event counters. Arms on a sys_start rising edge.
//  Clears the bank, then counts per-event valids plus elapsed cycles until sys_done or timeout.
//  Then serialises the results over a valid/ready dump stream.
//  Sits between the top-level start/done handshake and the host/debug readout path.
// PARAMETERS
//  CNT_W   32                    width of every counter and of dump_data
//  NUM_EV  4                     number of event inputs counted in parallel (>=1)
//  IDX_W   $clog2(NUM_EV+1)      dump index width (derived localparam, not overridable)
// PORTS
//  clk          in   1        single clock; all logic on posedge
//  rst          in   1        synchronous, active-high reset
//  sys_start    in   1        level; rising edge arms a run
//  sys_done     in   1        level; sampled only in RUN, ends the run
//  ev_vld       in   NUM_EV   per-event increment strobe, one count per cycle per bit
//  cfg_max_cyc  in   CNT_W    run cycle limit; 0 = no limit; sampled in CLEAR
//  busy         out  1        high in any state other than IDLE
//  run          out  1        high in RUN only
//  tmo_flag     out  1        run ended by cycle limit; held until next CLEAR or rst
//  dump_vld     out  1        dump beat valid
//  dump_rdy     in   1        dump beat accepted when dump_vld & dump_rdy
//  dump_idx     out  IDX_W    0..NUM_EV-1 = event count i; NUM_EV = cycle count
//  dump_data    out  CNT_W    counter value for dump_idx
//  dump_last    out  1        high on final beat (dump_idx==NUM_EV)
// BEHAVIOUR
//  Reset: state=IDLE. All counters=0. busy=run=tmo_flag=dump_vld=dump_last=0. dump_idx=0.
//   The start-edge history register resets to 1, so a sys_start held high through rst does not arm.
//  Edge: start_pulse = sys_start & ~start_q. start_q <= sys_start every cycle.
//  FSM IDLE -> CLEAR -> RUN -> DUMP -> IDLE.
//   IDLE:  start_pulse -> CLEAR. sys_done is ignored, including when it coincides with the pulse.
//   CLEAR: one cycle. All counters <= 0, tmo_flag <= 0, latch cfg_max_cyc. -> RUN.
//   RUN:   cyc_cnt += 1 each cycle. ev_cnt[i] += 1 when ev_vld[i].
//          Each counter saturates at all-ones; it never wraps.
//          Exit to DUMP when sys_done=1. The events of that cycle are counted.
//          Also exit to DUMP when the latched limit is nonzero and cyc_cnt+1 == limit;
//          tmo_flag <= 1 on that edge.
//          If both exit conditions are true in the same cycle, sys_done wins and tmo_flag stays 0.
//   DUMP:  dump_vld=1. Beats run dump_idx 0..NUM_EV. dump_data, dump_idx and dump_last stay
//          stable while dump_vld & ~dump_rdy. Advance one beat per handshake.
//          The handshake with dump_last=1 moves to IDLE, and dump_vld drops the next cycle.
//  start_pulse in CLEAR, RUN or DUMP is ignored (no restart, no abort).
//  ev_vld outside RUN is ignored. Counters hold their values after DUMP until the next CLEAR.
//  Latency: pulse at cycle T -> CLEAR at T+1 -> run=1 and first counted events at T+2.
//   sys_done at cycle D -> dump_vld=1 at D+1.
//  Limit L>0: exactly L cycles in RUN. cyc_cnt dumps as L. tmo_flag=1.
//  rst mid-run or mid-dump: immediate return to reset values; the partial dump is discarded.
// STRUCTURE
//  cnt_run_pkg (shared .vh): state localparams ST_IDLE/ST_CLEAR/ST_RUN/ST_DUMP (2b),
//   plus a DUMP_CYC_IDX = NUM_EV helper macro.
//  Sub-module sat_cnt #(CNT_W): ports clk, rst, clr, en, q.
//   Synchronous clear has priority over en. Saturating increment.
//   Instantiate NUM_EV+1 times (events plus cycle counter).
//  Top level: FSM, edge detect, limit compare, dump mux.
// TESTING
//  1 NUM_EV=4, limit=0. Start edge, 10 RUN cycles with ev_vld=4'b0101, then sys_done
//    -> 5 beats: 10,0,10,0,10. dump_last on idx 4. tmo_flag=0.
//  2 limit=7, no sys_done, ev_vld=4'b1111 -> run high for exactly 7 cycles.
//    All 5 beats = 7. tmo_flag=1.
//  3 Backpressure: dump_rdy toggled 1010..., then held low 5 cycles mid-dump
//    -> data/idx stable while stalled. No beat lost or duplicated.
//  4 CNT_W=4, ev_vld[0]=1 for 20 RUN cycles -> ev0 dumps 15 (saturated), cyc dumps 15.
//  5 sys_start high through rst release -> no run. Low then high -> run starts.
//    Second edge during RUN is ignored.
//  6 rst during DUMP beat 2 -> next cycle dump_vld=0, busy=0.
//    A new start produces a fresh run with counters starting from 0.

Source files
------------

// File: rtl/cnt_run_ctrl_pkg.sv
// Shared definitions for the counter run-window controller.
package cnt_run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DUMP  = 2'd3
   } state_t;

endpackage

// File: rtl/cnt_run_ctrl_if.sv
// Result dump stream: one beat per counter, cycle count last, valid/ready handshake.
interface cnt_run_ctrl_if #(
   parameter int CNT_W  = 32,
   parameter int NUM_EV = 4
);
   localparam int IDX_W = $clog2(NUM_EV + 1);

   logic             dump_vld;
   logic             dump_rdy;
   logic [IDX_W-1:0] dump_idx;
   logic [CNT_W-1:0] dump_data;
   logic             dump_last;

   modport master (output dump_vld, dump_idx, dump_data, dump_last, input dump_rdy);
   modport slave  (input dump_vld, dump_idx, dump_data, dump_last, output dump_rdy);
endinterface

// File: rtl/cnt_run_ctrl_sat_cnt.sv
// Saturating up-counter; synchronous clear beats enable, sticks at all-ones.
module cnt_run_ctrl_sat_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] q
);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;
endmodule

// File: rtl/cnt_run_ctrl.sv
// Run-window controller: start edge arms, CLEAR zeroes counters, RUN counts, DUMP serialises results.
// Start pulse -> run two cycles later; sys_done or limit -> dump_vld next cycle; beats held until dump_rdy.
module cnt_run_ctrl
   import cnt_run_ctrl_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int NUM_EV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sys_start_i,
   input  logic              sys_done_i,
   input  logic [NUM_EV-1:0] ev_vld_i,
   input  logic [CNT_W-1:0]  cfg_max_cyc_i,
   output logic              busy_o,
   output logic              run_o,
   output logic              tmo_flag_o,
   cnt_run_ctrl_if.master    dump
);
   localparam int               IDX_W    = $clog2(NUM_EV + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EV);

   state_t           state_q;
   logic             start_q;
   logic             busy_q;
   logic             run_q;
   logic             vld_q;
   logic             tmo_q;
   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] lim_q;
   logic [CNT_W-1:0] cnt [NUM_EV+1];
   logic             start_pulse;
   logic             lim_hit;
   logic             clr;
   logic             last;
   logic [CNT_W-1:0] dump_mux;

   assign start_pulse = sys_start_i & ~start_q;
   assign clr         = (state_q == ST_CLEAR);
   // cnt[NUM_EV] is the cycle counter; the limit fires on the cycle that will make it reach L.
   assign lim_hit     = (lim_q != '0) && ((cnt[NUM_EV] + CNT_W'(1)) == lim_q);
   assign last        = (idx_q == LAST_IDX);

   for (genvar i = 0; i < NUM_EV; i++) begin : g_ev
      cnt_run_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_ev_cnt (
         .clk (clk),
         .rst (rst),
         .clr (clr),
         .en  (run_q & ev_vld_i[i]),
         .q   (cnt[i])
      );
   end

   cnt_run_ctrl_sat_cnt #(.CNT_W(CNT_W)) u_cyc_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (run_q),
      .q   (cnt[NUM_EV])
   );

   always_comb begin
      dump_mux = '0;
      for (int i = 0; i <= NUM_EV; i++) begin
         if (idx_q == IDX_W'(i)) dump_mux = cnt[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         start_q <= 1'b1;
         busy_q  <= 1'b0;
         run_q   <= 1'b0;
         vld_q   <= 1'b0;
         tmo_q   <= 1'b0;
         idx_q   <= '0;
         lim_q   <= '0;
      end else begin
         start_q <= sys_start_i;
         case (state_q)
            ST_IDLE: begin
               if (start_pulse) begin
                  state_q <= ST_CLEAR;
                  busy_q  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               state_q <= ST_RUN;
               run_q   <= 1'b1;
               tmo_q   <= 1'b0;
               idx_q   <= '0;
               lim_q   <= cfg_max_cyc_i;
            end
            ST_RUN: begin
               if (sys_done_i || lim_hit) begin
                  state_q <= ST_DUMP;
                  run_q   <= 1'b0;
                  vld_q   <= 1'b1;
                  tmo_q   <= ~sys_done_i;
               end
            end
            ST_DUMP: begin
               if (dump.dump_rdy) begin
                  if (last) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     vld_q   <= 1'b0;
                     idx_q   <= '0;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o         = busy_q;
   assign run_o          = run_q;
   assign tmo_flag_o     = tmo_q;
   assign dump.dump_vld  = vld_q;
   assign dump.dump_idx  = idx_q;
   assign dump.dump_data = dump_mux;
   assign dump.dump_last = vld_q & last;
endmodule

// File: tb/tb_cnt_run_ctrl.sv
// Directed bench: a 32-bit and a 4-bit instance share stimulus and dump_rdy, checked beat by beat.
module tb_cnt_run_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sys_start = 1'b0;
   logic        sys_done = 1'b0;
   logic [3:0]  ev_vld = 4'b0;
   logic [31:0] cfg_max_cyc = 32'd0;
   logic        b_busy, b_run, b_tmo;
   logic        s_busy, s_run, s_tmo;
   int          n_chk = 0;
   int          n_err = 0;
   int          exp_b[5];
   int          exp_s[5];
   int          rc;

   cnt_run_ctrl_if #(.CNT_W(32), .NUM_EV(4)) dif ();
   cnt_run_ctrl_if #(.CNT_W(4),  .NUM_EV(4)) sif ();

   cnt_run_ctrl #(.CNT_W(32), .NUM_EV(4)) u_big (
      .clk           (clk),
      .rst           (rst),
      .sys_start_i   (sys_start),
      .sys_done_i    (sys_done),
      .ev_vld_i      (ev_vld),
      .cfg_max_cyc_i (cfg_max_cyc),
      .busy_o        (b_busy),
      .run_o         (b_run),
      .tmo_flag_o    (b_tmo),
      .dump          (dif)
   );

   cnt_run_ctrl #(.CNT_W(4), .NUM_EV(4)) u_sml (
      .clk           (clk),
      .rst           (rst),
      .sys_start_i   (sys_start),
      .sys_done_i    (sys_done),
      .ev_vld_i      (ev_vld),
      .cfg_max_cyc_i (cfg_max_cyc[3:0]),
      .busy_o        (s_busy),
      .run_o         (s_run),
      .tmo_flag_o    (s_tmo),
      .dump          (sif)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Arms a run, optionally raises sys_done after n_done RUN cycles; returns on the first dump_vld sample.
   task automatic do_run(input int n_done, input bit glitch, output int rcnt);
      int i_done = -1;
      int i_vld  = -1;
      rcnt = 0;
      sys_start = 1'b1;
      sys_done  = (n_done != 0);
      tick;
      sys_start = 1'b0;
      sys_done  = 1'b0;
      check_eq("clear busy", b_busy, 1);
      check_eq("clear run", b_run, 0);
      for (int i = 0; i < 200; i++) begin
         tick;
         if (b_run) rcnt++;
         if (dif.dump_vld) begin
            i_vld = i;
            break;
         end
         if (glitch && rcnt == 2) sys_start = 1'b1;
         if (n_done != 0 && rcnt == n_done && i_done < 0) begin
            sys_done = 1'b1;
            i_done   = i;
         end
      end
      sys_done  = 1'b0;
      sys_start = 1'b0;
      check_eq("dump_vld reached", i_vld >= 0, 1);
      check_eq("sml in lockstep", s_busy & ~s_run, 1);
      if (n_done != 0) check_eq("done to vld latency", i_vld - i_done, 1);
   endtask

   task automatic collect_dump(input string tag, input bit bp);
      int   beat = 0;
      logic rdy;
      for (int k = 0; k < 60 && beat < 5; k++) begin
         rdy = bp ? ((k >= 3 && k < 8) ? 1'b0 : (k % 2 == 0)) : 1'b1;
         check_eq({tag, " vld"}, dif.dump_vld, 1);
         check_eq({tag, " idx"}, dif.dump_idx, beat);
         check_eq({tag, " data"}, dif.dump_data, exp_b[beat]);
         check_eq({tag, " sml data"}, sif.dump_data, exp_s[beat]);
         check_eq({tag, " last"}, dif.dump_last, beat == 4);
         if (rdy) beat++;
         dif.dump_rdy = rdy;
         sif.dump_rdy = rdy;
         tick;
      end
      dif.dump_rdy = 1'b0;
      sif.dump_rdy = 1'b0;
      check_eq({tag, " beats"}, beat, 5);
      check_eq({tag, " vld after"}, dif.dump_vld, 0);
      check_eq({tag, " busy after"}, b_busy, 0);
      check_eq({tag, " sml vld after"}, sif.dump_vld, 0);
   endtask

   initial begin
      dif.dump_rdy = 1'b0;
      sif.dump_rdy = 1'b0;
      tick;
      tick;
      check_eq("rst busy", b_busy, 0);
      check_eq("rst run", b_run, 0);
      check_eq("rst tmo", b_tmo, 0);
      check_eq("rst vld", dif.dump_vld, 0);
      check_eq("rst last", dif.dump_last, 0);
      check_eq("rst idx", dif.dump_idx, 0);
      rst = 1'b0;
      tick;

      // Done-terminated run with a mixed event pattern.
      cfg_max_cyc = 32'd0;
      ev_vld = 4'b0101;
      do_run(10, 1'b0, rc);
      check_eq("t1 run cycles", rc, 10);
      check_eq("t1 tmo", b_tmo, 0);
      exp_b = '{10, 0, 10, 0, 10};
      exp_s = '{10, 0, 10, 0, 10};
      collect_dump("t1", 1'b0);

      // sys_done and limit in the same cycle: done wins, no timeout.
      cfg_max_cyc = 32'd5;
      ev_vld = 4'b0010;
      do_run(5, 1'b0, rc);
      check_eq("tboth run cycles", rc, 5);
      check_eq("tboth tmo", b_tmo, 0);
      exp_b = '{0, 5, 0, 0, 5};
      exp_s = '{0, 5, 0, 0, 5};
      collect_dump("tboth", 1'b0);

      // Limit-terminated run.
      cfg_max_cyc = 32'd7;
      ev_vld = 4'b1111;
      do_run(0, 1'b0, rc);
      check_eq("t2 run cycles", rc, 7);
      check_eq("t2 tmo", b_tmo, 1);
      check_eq("t2 sml tmo", s_tmo, 1);
      exp_b = '{7, 7, 7, 7, 7};
      exp_s = '{7, 7, 7, 7, 7};
      collect_dump("t2", 1'b0);
      check_eq("t2 tmo held", b_tmo, 1);

      // Backpressure: alternating ready with a 5-cycle stall.
      cfg_max_cyc = 32'd3;
      ev_vld = 4'b0011;
      do_run(0, 1'b0, rc);
      check_eq("t3 run cycles", rc, 3);
      exp_b = '{3, 3, 0, 0, 3};
      exp_s = '{3, 3, 0, 0, 3};
      collect_dump("t3", 1'b1);

      // Saturation on the 4-bit instance; clear of previous counts and tmo.
      cfg_max_cyc = 32'd0;
      ev_vld = 4'b0001;
      do_run(20, 1'b0, rc);
      check_eq("t4 run cycles", rc, 20);
      check_eq("t4 tmo cleared", b_tmo, 0);
      exp_b = '{20, 0, 0, 0, 20};
      exp_s = '{15, 0, 0, 0, 15};
      collect_dump("t4", 1'b0);

      // sys_start held high through reset must not arm; a second edge in RUN is ignored.
      sys_start = 1'b1;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      tick;
      tick;
      tick;
      check_eq("t5 no arm", b_busy, 0);
      sys_start = 1'b0;
      tick;
      ev_vld = 4'b1000;
      do_run(4, 1'b1, rc);
      check_eq("t5 run cycles", rc, 4);
      exp_b = '{0, 0, 0, 4, 4};
      exp_s = '{0, 0, 0, 4, 4};
      collect_dump("t5", 1'b0);

      // Reset in the middle of the dump, then a fresh run.
      ev_vld = 4'b0110;
      do_run(3, 1'b0, rc);
      dif.dump_rdy = 1'b1;
      sif.dump_rdy = 1'b1;
      tick;
      tick;
      check_eq("t6 idx before rst", dif.dump_idx, 2);
      check_eq("t6 data before rst", dif.dump_data, 3);
      dif.dump_rdy = 1'b0;
      sif.dump_rdy = 1'b0;
      rst = 1'b1;
      tick;
      check_eq("t6 rst vld", dif.dump_vld, 0);
      check_eq("t6 rst busy", b_busy, 0);
      check_eq("t6 rst idx", dif.dump_idx, 0);
      rst = 1'b0;
      tick;
      ev_vld = 4'b0001;
      do_run(2, 1'b0, rc);
      check_eq("t6 run cycles", rc, 2);
      exp_b = '{2, 0, 0, 0, 2};
      exp_s = '{2, 0, 0, 0, 2};
      collect_dump("t6", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
